// File: rtl/tu_pkg.sv
// Shared definitions for the trigger-unit hit capture block.
// Holds the default word/timestamp widths and the one-hot FSM state encoding.
package tu_pkg;

    localparam int unsigned TU_DATA_W = 64;
    localparam int unsigned TU_TS_W   = 16;

    // One-hot run-control states.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_ARMED = 4'b0010,
        ST_RUN   = 4'b0100,
        ST_STOP  = 4'b1000
    } tu_state_e;

endpackage

// File: rtl/tu_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset
//   flush_i        drop all contents (wins over push/pop)
//   wr_en_i, din_i push din_i; ignored when full unless a pop happens in the same cycle
//   rd_en_i        pop head; ignored when empty
//   dout_o         head entry, valid whenever empty_o=0 (reads 0 when empty)
//   empty_o, full_o, level_o  occupancy status
module tu_sync_fifo #(
    parameter int unsigned WIDTH = 80,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [AW:0]      level_o
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_pop;
    logic             do_push;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // A pop frees the slot at this edge, so a push on full still succeeds alongside it.
    assign do_pop  = rd_en_i & ~empty_o;
    assign do_push = wr_en_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/tu_hit_capture.sv
// Trigger hit capture: registers the aligned trigger word, and while a run is active pushes every
// non-zero word tagged with a free-running timestamp into a FWFT FIFO for processor readout.
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN   clock, synchronous active-low reset
//   aligned_valid, trig_data    aligner status and aligned word (registered once on entry)
//   capture_ena                 run control: rising edge arms, low ends the run
//   rd_en, rd_data, rd_empty    FIFO readout, rd_data = {ts, word}
//   fifo_full, fill_level       FIFO occupancy
//   run_active, align_lost      run status; align_lost is sticky until the next arm
//   hit_cnt, drop_cnt           saturating per-run statistics
module tu_hit_capture import tu_pkg::*; #(
    parameter int unsigned DATA_W  = TU_DATA_W,
    parameter int unsigned TS_W    = TU_TS_W,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned CNT_W   = 32,
    localparam int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic                   S_AXI_ACLK,
    input  logic                   S_AXI_ARESETN,
    input  logic                   aligned_valid,
    input  logic [DATA_W-1:0]      trig_data,
    input  logic                   capture_ena,
    input  logic                   rd_en,
    output logic [TS_W+DATA_W-1:0] rd_data,
    output logic                   rd_empty,
    output logic                   fifo_full,
    output logic [LVL_W-1:0]       fill_level,
    output logic                   run_active,
    output logic                   align_lost,
    output logic [CNT_W-1:0]       hit_cnt,
    output logic [15:0]            drop_cnt
);

    tu_state_e         state_q, state_d;
    logic [DATA_W-1:0] trig_q;
    logic              valid_q;
    logic              cena_q;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [CNT_W-1:0]  hit_q, hit_d;
    logic [15:0]       drop_q, drop_d;
    logic              lost_q, lost_d;
    logic              push;
    logic              flush;
    logic              space;

    // Full plus a same-cycle pop still counts as room.
    assign space = ~fifo_full | rd_en;

    always_comb begin
        state_d = state_q;
        ts_d    = ts_q;
        hit_d   = hit_q;
        drop_d  = drop_q;
        lost_d  = lost_q;
        push    = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (capture_ena && !cena_q) begin
                    state_d = ST_ARMED;
                    flush   = 1'b1;
                    ts_d    = '0;
                    hit_d   = '0;
                    drop_d  = '0;
                    lost_d  = 1'b0;
                end
            end
            ST_ARMED: begin
                if (!capture_ena)  state_d = ST_IDLE;
                else if (valid_q)  state_d = ST_RUN;
            end
            ST_RUN: begin
                ts_d = ts_q + 1'b1;
                // The word in the exit cycle is still handled before leaving.
                if (|trig_q) begin
                    if (space) begin
                        push = 1'b1;
                        if (hit_q != '1) hit_d = hit_q + 1'b1;
                    end else if (drop_q != '1) begin
                        drop_d = drop_q + 1'b1;
                    end
                end
                if (!valid_q) begin
                    state_d = ST_STOP;
                    lost_d  = 1'b1;
                end else if (!capture_ena) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state_q <= ST_IDLE;
            trig_q  <= '0;
            valid_q <= 1'b0;
            cena_q  <= 1'b0;
            ts_q    <= '0;
            hit_q   <= '0;
            drop_q  <= '0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            trig_q  <= trig_data;
            valid_q <= aligned_valid;
            cena_q  <= capture_ena;
            ts_q    <= ts_d;
            hit_q   <= hit_d;
            drop_q  <= drop_d;
            lost_q  <= lost_d;
        end
    end

    tu_sync_fifo #(
        .WIDTH (TS_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (S_AXI_ACLK),
        .rst_ni  (S_AXI_ARESETN),
        .flush_i (flush),
        .wr_en_i (push),
        .din_i   ({ts_q, trig_q}),
        .rd_en_i (rd_en),
        .dout_o  (rd_data),
        .empty_o (rd_empty),
        .full_o  (fifo_full),
        .level_o (fill_level)
    );

    assign run_active = (state_q == ST_RUN);
    assign align_lost = lost_q;
    assign hit_cnt    = hit_q;
    assign drop_cnt   = drop_q;

endmodule
